// File: rtl/pcpi_coproc_sched_pkg.sv
// Shared types and constants for the PCPI coprocessor scheduler.
package pcpi_coproc_sched_pkg;

    // Width of the PCPI data paths (insn, rs1, rs2, rd).
    localparam int XLEN = 32;

    // Scheduler FSM states; encodings are fixed so they read the same in waveforms.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLAIM = 3'd1,
        ST_BUSY  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/pcpi_prio_onehot.sv
// Lowest-index-wins one-hot select with a flag for more than one request.
module pcpi_prio_onehot #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot,
    output logic         multi
);

    // Isolate the lowest set bit; anything left over means several requesters.
    always_comb begin
        onehot = req & (~req + N'(1));
        multi  = |(req & ~onehot);
    end

endmodule

// File: rtl/pcpi_coproc_sched.sv
// Scheduler between the picorv32 PCPI port and N_CP coprocessors: broadcasts
// the request, latches the first claimant as owner and returns only its result.
module pcpi_coproc_sched
    import pcpi_coproc_sched_pkg::*;
#(
    parameter int N_CP          = 4,
    parameter int CLAIM_TIMEOUT = 12,  // keep below the CPU's 16-cycle PCPI trap window
    parameter int BUSY_TIMEOUT  = 0,   // 0 disables the busy watchdog
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 pcpi_valid,
    input  logic [XLEN-1:0]      pcpi_insn,
    input  logic [XLEN-1:0]      pcpi_rs1,
    input  logic [XLEN-1:0]      pcpi_rs2,
    output logic                 pcpi_wr,
    output logic [XLEN-1:0]      pcpi_rd,
    output logic                 pcpi_wait,
    output logic                 pcpi_ready,
    output logic [N_CP-1:0]      cp_valid,
    output logic [XLEN-1:0]      cp_insn,
    output logic [XLEN-1:0]      cp_rs1,
    output logic [XLEN-1:0]      cp_rs2,
    input  logic [N_CP-1:0]      cp_wr,
    input  logic [XLEN*N_CP-1:0] cp_rd,
    input  logic [N_CP-1:0]      cp_wait,
    input  logic [N_CP-1:0]      cp_ready,
    input  logic [N_CP-1:0]      en_mask,
    input  logic                 err_clear,
    output logic                 err_multi,
    output logic                 err_timeout,
    output logic [N_CP-1:0]      owner
);

    localparam logic [CNT_W-1:0] CLAIM_LIM = CNT_W'(CLAIM_TIMEOUT);
    localparam logic [CNT_W-1:0] BUSY_LIM  = CNT_W'(BUSY_TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [N_CP-1:0]  claim;
    logic [N_CP-1:0]  sel;
    logic             multi;
    logic [N_CP-1:0]  mask;
    logic [N_CP-1:0]  src;
    logic [XLEN-1:0]  rd_mux;
    logic             wr_mux;

    // Operands go to every coprocessor unregistered; only valid is gated.
    assign cp_insn = pcpi_insn;
    assign cp_rs1  = pcpi_rs1;
    assign cp_rs2  = pcpi_rs2;

    // A disabled coprocessor can never claim, whatever it drives.
    assign claim = (cp_wait | cp_ready) & en_mask;

    pcpi_prio_onehot #(.N(N_CP)) u_prio (
        .req    (claim),
        .onehot (sel),
        .multi  (multi)
    );

    // Gate valid: broadcast while looking for a claimant, owner only once busy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mask = '0;
        unique case (state)
            ST_IDLE, ST_CLAIM: mask = '1;
            ST_BUSY:           mask = owner;
            default:           mask = '0;
        endcase
        cp_valid = {N_CP{pcpi_valid}} & en_mask & mask;
    end

    // AND-OR result mux over the one-hot source (the fresh claimant in CLAIM, else the owner).
    always_comb begin
        src     = (state == ST_CLAIM) ? sel : owner;
        rd_mux  = '0;
        wr_mux  = 1'b0;
        for (int i = 0; i < N_CP; i++) begin
            rd_mux = rd_mux | (cp_rd[XLEN*i +: XLEN] & {XLEN{src[i]}});
            wr_mux = wr_mux | (cp_wr[i] & src[i]);
        end
    end

    // Saturating increment shared by the claim and busy watchdogs.
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

    // Scheduler FSM with registered PCPI outputs and sticky error flags.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; later assignments in
        // this block deliberately override the defaults written above them.
        if (!resetn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            owner       <= '0;
            pcpi_wr     <= 1'b0;
            pcpi_rd     <= '0;
            pcpi_wait   <= 1'b0;
            pcpi_ready  <= 1'b0;
            err_multi   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            // Result and handshake are zero unless a branch below drives them.
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= '0;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b0;

            // Clear first so a set event in the same cycle wins.
            if (err_clear) begin
                err_multi   <= 1'b0;
                err_timeout <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    owner <= '0;
                    if (pcpi_valid) begin
                        cnt   <= '0;
                        state <= ST_CLAIM;
                    end
                end

                ST_CLAIM: begin
                    if (!pcpi_valid) begin
                        owner <= '0;
                        state <= ST_IDLE;
                    end else if (|claim) begin
                        owner <= sel;
                        if (multi) err_multi <= 1'b1;
                        if (|(sel & cp_ready)) begin
                            pcpi_ready <= 1'b1;
                            pcpi_wr    <= wr_mux;
                            pcpi_rd    <= rd_mux;
                            state      <= ST_DONE;
                        end else begin
                            pcpi_wait <= 1'b1;
                            cnt       <= '0;
                            state     <= ST_BUSY;
                        end
                    end else begin
                        cnt <= cnt_inc;
                        // Nobody claimed: drop silently so the CPU raises its illegal-insn trap.
                        if (cnt_inc == CLAIM_LIM) state <= ST_DRAIN;
                    end
                end

                ST_BUSY: begin
                    if (!pcpi_valid) begin
                        // CPU gave up; the coprocessor is simply abandoned.
                        owner <= '0;
                        state <= ST_IDLE;
                    end else if (|(owner & en_mask & cp_ready)) begin
                        pcpi_ready <= 1'b1;
                        pcpi_wr    <= wr_mux;
                        pcpi_rd    <= rd_mux;
                        state      <= ST_DONE;
                    end else if (BUSY_TIMEOUT != 0 && cnt_inc == BUSY_LIM) begin
                        // Forced completion with no writeback.
                        pcpi_ready  <= 1'b1;
                        err_timeout <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        pcpi_wait <= 1'b1;
                        cnt       <= cnt_inc;
                    end
                end

                ST_DONE: begin
                    owner <= '0;
                    state <= pcpi_valid ? ST_DRAIN : ST_IDLE;
                end

                ST_DRAIN: begin
                    owner <= '0;
                    if (!pcpi_valid) state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcpi_coproc_sched.sv
// Directed bench for pcpi_coproc_sched: one instance with the busy watchdog
// disabled and one with BUSY_TIMEOUT=8, both driven by the same stimulus.
module tb_pcpi_coproc_sched;

    logic         clk = 1'b0;
    logic         resetn;
    logic         pcpi_valid;
    logic [31:0]  pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic [3:0]   cp_wr, cp_wait, cp_ready, en_mask;
    logic [127:0] cp_rd;
    logic         err_clear;

    logic         pcpi_wr, pcpi_wait, pcpi_ready, err_multi, err_timeout;
    logic [31:0]  pcpi_rd, cp_insn, cp_rs1, cp_rs2;
    logic [3:0]   cp_valid, owner;

    logic         wd_pcpi_wr, wd_pcpi_wait, wd_pcpi_ready, wd_err_multi, wd_err_timeout;
    logic [31:0]  wd_pcpi_rd, wd_cp_insn, wd_cp_rs1, wd_cp_rs2;
    logic [3:0]   wd_cp_valid, wd_owner;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pcpi_coproc_sched dut (
        .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready), .cp_valid(cp_valid),
        .cp_insn(cp_insn), .cp_rs1(cp_rs1), .cp_rs2(cp_rs2), .cp_wr(cp_wr), .cp_rd(cp_rd),
        .cp_wait(cp_wait), .cp_ready(cp_ready), .en_mask(en_mask), .err_clear(err_clear),
        .err_multi(err_multi), .err_timeout(err_timeout), .owner(owner)
    );

    pcpi_coproc_sched #(.BUSY_TIMEOUT(8)) dut_wd (
        .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(wd_pcpi_wr), .pcpi_rd(wd_pcpi_rd),
        .pcpi_wait(wd_pcpi_wait), .pcpi_ready(wd_pcpi_ready), .cp_valid(wd_cp_valid),
        .cp_insn(wd_cp_insn), .cp_rs1(wd_cp_rs1), .cp_rs2(wd_cp_rs2), .cp_wr(cp_wr), .cp_rd(cp_rd),
        .cp_wait(cp_wait), .cp_ready(cp_ready), .en_mask(en_mask), .err_clear(err_clear),
        .err_multi(wd_err_multi), .err_timeout(wd_err_timeout), .owner(wd_owner)
    );

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_cp();
        cp_wr = '0; cp_wait = '0; cp_ready = '0; cp_rd = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(2);
        if ({pcpi_wr, pcpi_wait, pcpi_ready} !== 3'b000) begin $display("FAIL reset_hs: got %b want 000", {pcpi_wr, pcpi_wait, pcpi_ready}); errors++; end checks++;
        if (pcpi_rd !== 32'h0) begin $display("FAIL reset_rd: got %h want 0", pcpi_rd); errors++; end checks++;
        if ({err_multi, err_timeout, owner, cp_valid} !== 10'b0) begin $display("FAIL reset_misc: got %b want 0", {err_multi, err_timeout, owner, cp_valid}); errors++; end checks++;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_fast_ready();
        pcpi_valid = 1'b1;
        #1;
        if (cp_valid !== 4'b1111) begin $display("FAIL t1_idle_bcast: got %b want 1111", cp_valid); errors++; end checks++;
        if ({cp_insn, cp_rs1, cp_rs2} !== {32'h0200_00B3, 32'h0000_0006, 32'h0000_0007}) begin $display("FAIL t1_fanout: got %h %h %h", cp_insn, cp_rs1, cp_rs2); errors++; end checks++;
        if ({wd_cp_insn, wd_cp_rs1, wd_cp_rs2} !== {32'h0200_00B3, 32'h0000_0006, 32'h0000_0007}) begin $display("FAIL t1_wd_fanout: got %h %h %h", wd_cp_insn, wd_cp_rs1, wd_cp_rs2); errors++; end checks++;
        tick();                                  // now CLAIM
        cp_ready = 4'b0001; cp_wr = 4'b0001; cp_rd[31:0] = 32'h0000_0042;
        tick();                                  // now DONE
        clear_cp();
        if ({pcpi_ready, pcpi_wr, pcpi_wait} !== 3'b110) begin $display("FAIL t1_done_hs: got %b want 110", {pcpi_ready, pcpi_wr, pcpi_wait}); errors++; end checks++;
        if (pcpi_rd !== 32'h0000_0042) begin $display("FAIL t1_rd: got %h want 00000042", pcpi_rd); errors++; end checks++;
        if (cp_valid !== 4'b0000) begin $display("FAIL t1_done_cpvalid: got %b want 0000", cp_valid); errors++; end checks++;
        pcpi_valid = 1'b0;
        tick();                                  // DONE -> IDLE
        if ({pcpi_ready, pcpi_wr, pcpi_rd} !== 34'b0) begin $display("FAIL t1_pulse_end: got %b %b %h want 0", pcpi_ready, pcpi_wr, pcpi_rd); errors++; end checks++;
    endtask

    task automatic test_div_wait();
        int bad;
        bad = 0;
        pcpi_valid = 1'b1;
        tick();                                  // CLAIM
        cp_wait = 4'b0010;
        tick();                                  // BUSY, owner = div
        if ({pcpi_wait, pcpi_ready} !== 2'b10) begin $display("FAIL t2_busy_hs: got %b want 10", {pcpi_wait, pcpi_ready}); errors++; end checks++;
        if (owner !== 4'b0010) begin $display("FAIL t2_owner: got %b want 0010", owner); errors++; end checks++;
        if (cp_valid !== 4'b0010) begin $display("FAIL t2_cpvalid: got %b want 0010", cp_valid); errors++; end checks++;
        for (int i = 0; i < 33; i++) begin
            tick();
            if (pcpi_wait !== 1'b1 || pcpi_ready !== 1'b0 || cp_valid !== 4'b0010) bad++;
        end
        if (bad !== 0) begin $display("FAIL t2_hold: %0d bad cycles, want 0", bad); errors++; end checks++;
        cp_wait = 4'b0000; cp_ready = 4'b0010; cp_wr = 4'b0010; cp_rd[63:32] = 32'hFFFF_FFFD;
        tick();                                  // DONE
        if ({pcpi_ready, pcpi_wr, pcpi_wait} !== 3'b110) begin $display("FAIL t2_done_hs: got %b want 110", {pcpi_ready, pcpi_wr, pcpi_wait}); errors++; end checks++;
        if (pcpi_rd !== 32'hFFFF_FFFD) begin $display("FAIL t2_rd: got %h want FFFFFFFD", pcpi_rd); errors++; end checks++;
        pcpi_valid = 1'b0;
        clear_cp();
        tick();
        if ({pcpi_ready, pcpi_wr, pcpi_rd} !== 34'b0) begin $display("FAIL t2_one_pulse: got %b %b %h want 0", pcpi_ready, pcpi_wr, pcpi_rd); errors++; end checks++;
    endtask

    task automatic test_multi_claim();
        pcpi_valid = 1'b1;
        tick();                                  // CLAIM
        cp_wait = 4'b1010;
        err_clear = 1'b1;                        // set must beat clear
        tick();                                  // BUSY
        err_clear = 1'b0;
        if (owner !== 4'b0010) begin $display("FAIL t3_owner: got %b want 0010", owner); errors++; end checks++;
        if (err_multi !== 1'b1) begin $display("FAIL t3_err_multi: got %b want 1", err_multi); errors++; end checks++;
        if ({wd_owner, wd_err_multi} !== 5'b0010_1) begin $display("FAIL t3_wd_owner: got %b %b want 0010 1", wd_owner, wd_err_multi); errors++; end checks++;
        if (cp_valid !== 4'b0010) begin $display("FAIL t3_cpvalid: got %b want 0010", cp_valid); errors++; end checks++;
        cp_ready = 4'b1000; cp_wr = 4'b1000; cp_rd[127:96] = 32'hDEAD_BEEF;
        tick(2);
        if ({pcpi_ready, pcpi_wait} !== 2'b01) begin $display("FAIL t3_nonowner_ignored: got %b want 01", {pcpi_ready, pcpi_wait}); errors++; end checks++;
        cp_wait = 4'b1000; cp_ready = 4'b0010; cp_wr = 4'b1010; cp_rd[63:32] = 32'h0000_1234;
        tick();                                  // DONE
        if ({pcpi_ready, pcpi_wr} !== 2'b11 || pcpi_rd !== 32'h0000_1234) begin $display("FAIL t3_done: got %b %h want 11 00001234", {pcpi_ready, pcpi_wr}, pcpi_rd); errors++; end checks++;
        clear_cp();
        tick();                                  // valid held -> DRAIN
        if (cp_valid !== 4'b0000 || pcpi_ready !== 1'b0 || pcpi_rd !== 32'h0) begin $display("FAIL t3_drain: got %b %b %h want 0000 0 0", cp_valid, pcpi_ready, pcpi_rd); errors++; end checks++;
        pcpi_valid = 1'b0;
        tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        if (err_multi !== 1'b0) begin $display("FAIL t3_err_clear: got %b want 0", err_multi); errors++; end checks++;
    endtask

    task automatic test_claim_timeout();
        int bad;
        bad = 0;
        pcpi_valid = 1'b1;
        tick();                                  // CLAIM entered
        for (int i = 0; i < 12; i++) begin
            if (cp_valid !== 4'b1111 || pcpi_ready !== 1'b0) bad++;
            tick();
        end
        if (bad !== 0) begin $display("FAIL t4_claim_window: %0d bad cycles, want 0", bad); errors++; end checks++;
        if (cp_valid !== 4'b0000 || pcpi_wait !== 1'b0) begin $display("FAIL t4_drain_entry: got %b %b want 0000 0", cp_valid, pcpi_wait); errors++; end checks++;
        cp_ready = 4'b0001;                      // late reply must be ignored in DRAIN
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pcpi_ready !== 1'b0 || cp_valid !== 4'b0000) bad++;
        end
        if (bad !== 0) begin $display("FAIL t4_drain_hold: %0d bad cycles, want 0", bad); errors++; end checks++;
        clear_cp();
        pcpi_valid = 1'b0;
        tick();                                  // DRAIN -> IDLE
        pcpi_valid = 1'b1;
        #1;
        if (cp_valid !== 4'b1111) begin $display("FAIL t4_back_idle: got %b want 1111", cp_valid); errors++; end checks++;
        pcpi_valid = 1'b0;
        tick();
    endtask

    task automatic test_busy_timeout();
        int bad;
        bad = 0;
        if (wd_err_timeout !== 1'b0) begin $display("FAIL t5_pre: got %b want 0", wd_err_timeout); errors++; end checks++;
        pcpi_valid = 1'b1;
        tick();                                  // CLAIM
        cp_wait = 4'b0100; cp_wr = 4'b0100; cp_rd[95:64] = 32'h5555_AAAA;
        tick();                                  // BUSY
        for (int i = 0; i < 7; i++) begin
            tick();
            if (wd_pcpi_ready !== 1'b0 || wd_pcpi_wait !== 1'b1) bad++;
        end
        if (bad !== 0) begin $display("FAIL t5_busy_window: %0d bad cycles, want 0", bad); errors++; end checks++;
        tick();                                  // 8th BUSY cycle -> forced DONE
        if ({wd_pcpi_ready, wd_pcpi_wr, wd_pcpi_wait} !== 3'b100 || wd_pcpi_rd !== 32'h0) begin $display("FAIL t5_forced_done: got %b %h want 100 0", {wd_pcpi_ready, wd_pcpi_wr, wd_pcpi_wait}, wd_pcpi_rd); errors++; end checks++;
        if (wd_err_timeout !== 1'b1) begin $display("FAIL t5_err_timeout: got %b want 1", wd_err_timeout); errors++; end checks++;
        if ({pcpi_ready, pcpi_wait, err_timeout} !== 3'b010) begin $display("FAIL t5_wd_disabled: got %b want 010", {pcpi_ready, pcpi_wait, err_timeout}); errors++; end checks++;
        tick();
        if (wd_pcpi_ready !== 1'b0 || wd_cp_valid !== 4'b0000) begin $display("FAIL t5_wd_drain: got %b %b want 0 0000", wd_pcpi_ready, wd_cp_valid); errors++; end checks++;
        pcpi_valid = 1'b0;
        clear_cp();
        tick();                                  // main: valid fell in BUSY -> IDLE
        if ({pcpi_wait, pcpi_ready, owner} !== 6'b0) begin $display("FAIL t5_abandon: got %b want 000000", {pcpi_wait, pcpi_ready, owner}); errors++; end checks++;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        if (wd_err_timeout !== 1'b0) begin $display("FAIL t5_err_clear: got %b want 0", wd_err_timeout); errors++; end checks++;
    endtask

    task automatic test_reset_busy_and_mask();
        pcpi_valid = 1'b1;
        tick();                                  // CLAIM
        cp_wait = 4'b0001;
        tick();                                  // BUSY owner 0001
        resetn = 1'b0;
        tick();
        if ({pcpi_wr, pcpi_wait, pcpi_ready, owner, err_multi, err_timeout} !== 9'b0 || pcpi_rd !== 32'h0) begin $display("FAIL t6_reset_outputs: got %b %h want 0", {pcpi_wr, pcpi_wait, pcpi_ready, owner}, pcpi_rd); errors++; end checks++;
        if (cp_valid !== 4'b1111) begin $display("FAIL t6_reset_idle: got %b want 1111", cp_valid); errors++; end checks++;
        resetn = 1'b1;
        pcpi_valid = 1'b0;
        clear_cp();
        tick();
        en_mask = 4'b1110;
        pcpi_valid = 1'b1;
        #1;
        if (cp_valid !== 4'b1110) begin $display("FAIL t6_mask_bcast: got %b want 1110", cp_valid); errors++; end checks++;
        tick();                                  // CLAIM
        cp_ready = 4'b0001; cp_wr = 4'b0001; cp_rd[31:0] = 32'h0000_0BAD;
        cp_wait = 4'b0100;
        tick();                                  // disabled idx 0 ignored -> BUSY owner 0100
        if (owner !== 4'b0100 || pcpi_ready !== 1'b0) begin $display("FAIL t6_mask_owner: got %b %b want 0100 0", owner, pcpi_ready); errors++; end checks++;
        if (cp_valid !== 4'b0100) begin $display("FAIL t6_mask_cpvalid: got %b want 0100", cp_valid); errors++; end checks++;
        cp_ready = 4'b0101; cp_wr = 4'b0101; cp_rd[95:64] = 32'h0000_0077;
        tick();                                  // DONE
        if (pcpi_ready !== 1'b1 || pcpi_rd !== 32'h0000_0077) begin $display("FAIL t6_mask_done: got %b %h want 1 00000077", pcpi_ready, pcpi_rd); errors++; end checks++;
        pcpi_valid = 1'b0;
        clear_cp();
        en_mask = 4'b1111;
        tick();
    endtask

    initial begin
        resetn     = 1'b0;
        pcpi_valid = 1'b0;
        pcpi_insn  = 32'h0200_00B3;
        pcpi_rs1   = 32'h0000_0006;
        pcpi_rs2   = 32'h0000_0007;
        en_mask    = 4'b1111;
        err_clear  = 1'b0;
        clear_cp();

        test_reset();
        test_fast_ready();
        test_div_wait();
        test_multi_claim();
        test_claim_timeout();
        test_busy_timeout();
        test_reset_busy_and_mask();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
